// File: rtl/rtc_timekeeper_pkg.sv
// Shared constants and helpers for the real-time clock (package rtc_pkg).
// Optional alarm feature is controlled by the RTC_ALARM_EN macro.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
    localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);

    // Convert an internal 0..23 hour into the 1..12 display form.
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour);
        if (hour == '0)
            return HOUR_W'(12);
        else if (hour > HOUR_W'(12))
            return hour - HOUR_W'(12);
        else
            return hour;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Control/load/status bundle of the real-time clock.
// The al_* members and alarm are only functional with RTC_ALARM_EN defined.
interface rtc_timekeeper_if;
    import rtc_pkg::*;

    logic              run;
    logic              mode_24h;
    logic              ld;
    logic [SEC_W-1:0]  ld_sec;
    logic [MIN_W-1:0]  ld_min;
    logic [HOUR_W-1:0] ld_hour;
    logic              ld_err;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hours;
    logic              pm;
    logic              sec_stb;
    logic              min_stb;
    logic              hour_stb;
    logic              day_stb;
    logic              al_ld;
    logic [MIN_W-1:0]  al_min;
    logic [HOUR_W-1:0] al_hour;
    logic              alarm;

    modport master (
        output run, mode_24h, ld, ld_sec, ld_min, ld_hour, al_ld, al_min, al_hour,
        input  ld_err, sec, min, hours, pm, sec_stb, min_stb, hour_stb, day_stb, alarm
    );

    modport slave (
        input  run, mode_24h, ld, ld_sec, ld_min, ld_hour, al_ld, al_min, al_hour,
        output ld_err, sec, min, hours, pm, sec_stb, min_stb, hour_stb, day_stb, alarm
    );

endinterface

// File: rtl/rtc_timekeeper_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles while run is high.
// clr restarts the count so a fresh second begins after a time load.
module rtc_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt;

    assign tick = run && (pcnt == LAST);

    // Count cycles of the current second; hold when stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (clr)
            pcnt <= '0;
        else if (run)
            pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time clock: seconds/minutes/hours with load, run/stop, 12h/24h display
// and rollover strobes. Optional alarm compare enabled by RTC_ALARM_EN.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int RST_HOUR = 0
) (
    input  logic           clk,
    input  logic           rst,
    rtc_timekeeper_if.slave bus
);

    logic              tick;
    logic              ld_ok;
    logic              ld_bad;
    logic              al_bad;
    logic [SEC_W-1:0]  sec_r;
    logic [MIN_W-1:0]  min_r;
    logic [HOUR_W-1:0] hour_r;
    logic              sec_stb_r, min_stb_r, hour_stb_r, day_stb_r;
    logic              ld_err_r;
    logic              sec_wrap, min_wrap, hour_wrap;
    logic [SEC_W-1:0]  sec_inc;
    logic [MIN_W-1:0]  min_inc;
    logic [HOUR_W-1:0] hour_inc;
    logic [MIN_W-1:0]  min_after;
    logic [HOUR_W-1:0] hour_after;

    rtc_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .run  (bus.run),
        .clr  (ld_ok),
        .tick (tick)
    );

    // Range check of a time load request.
    always_comb begin
        ld_bad = 1'b0;
        if (bus.ld && (bus.ld_sec > SEC_MAX || bus.ld_min > MIN_MAX || bus.ld_hour > HOUR_MAX))
            ld_bad = 1'b1;
        ld_ok = bus.ld && !ld_bad;
    end

    // Incremented field values and the time a tick would produce.
    always_comb begin
        sec_wrap   = (sec_r == SEC_MAX);
        min_wrap   = (min_r == MIN_MAX);
        hour_wrap  = (hour_r == HOUR_MAX);
        sec_inc    = sec_wrap  ? '0 : sec_r + SEC_W'(1);
        min_inc    = min_wrap  ? '0 : min_r + MIN_W'(1);
        hour_inc   = hour_wrap ? '0 : hour_r + HOUR_W'(1);
        min_after  = sec_wrap ? min_inc : min_r;
        hour_after = (sec_wrap && min_wrap) ? hour_inc : hour_r;
    end

    // Time state and strobes; an accepted load beats a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_r      <= '0;
            min_r      <= '0;
            hour_r     <= HOUR_W'(RST_HOUR);
            sec_stb_r  <= 1'b0;
            min_stb_r  <= 1'b0;
            hour_stb_r <= 1'b0;
            day_stb_r  <= 1'b0;
            ld_err_r   <= 1'b0;
        end else begin
            sec_stb_r  <= 1'b0;
            min_stb_r  <= 1'b0;
            hour_stb_r <= 1'b0;
            day_stb_r  <= 1'b0;
            ld_err_r   <= ld_bad || al_bad;
            if (ld_ok) begin
                sec_r  <= bus.ld_sec;
                min_r  <= bus.ld_min;
                hour_r <= bus.ld_hour;
            end else if (tick) begin
                sec_r     <= sec_inc;
                min_r     <= min_after;
                hour_r    <= hour_after;
                sec_stb_r <= 1'b1;
                if (sec_wrap) begin
                    min_stb_r <= 1'b1;
                    if (min_wrap) begin
                        hour_stb_r <= 1'b1;
                        if (hour_wrap)
                            day_stb_r <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic [MIN_W-1:0]  al_min_r;
    logic [HOUR_W-1:0] al_hour_r;
    logic              alarm_r;

    // Range check of an alarm load request.
    always_comb begin
        al_bad = bus.al_ld && (bus.al_min > MIN_MAX || bus.al_hour > HOUR_MAX);
    end

    // Alarm registers and the alarm pulse, which only a tick can trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_min_r  <= '0;
            al_hour_r <= '0;
            alarm_r   <= 1'b0;
        end else begin
            if (bus.al_ld && !al_bad) begin
                al_min_r  <= bus.al_min;
                al_hour_r <= bus.al_hour;
            end
            alarm_r <= !ld_ok && tick && sec_wrap &&
                       (min_after == al_min_r) && (hour_after == al_hour_r);
        end
    end

    assign bus.alarm = alarm_r;
`else
    logic unused_al;

    assign unused_al = ^{bus.al_ld, bus.al_min, bus.al_hour};
    assign al_bad    = 1'b0;
    assign bus.alarm = 1'b0;
`endif

    assign bus.sec      = sec_r;
    assign bus.min      = min_r;
    assign bus.hours    = bus.mode_24h ? hour_r : to_12h(hour_r);
    assign bus.pm       = (hour_r >= HOUR_W'(12));
    assign bus.sec_stb  = sec_stb_r;
    assign bus.min_stb  = min_stb_r;
    assign bus.hour_stb = hour_stb_r;
    assign bus.day_stb  = day_stb_r;
    assign bus.ld_err   = ld_err_r;

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised real-time clock. Counts seconds, minutes and hours from a system clock through an internal prescaler. Adds software time load with range checking, run/stop, runtime 12h/24h display mode with AM/PM flag, and single-cycle rollover strobes. Sits between the system clock domain and display/alarm logic; all outputs are synchronous to clk.

Parameters:
CLK_DIV, 1, clk cycles per second tick; legal range 1..2^24; 1 means one second per clk cycle.
RST_HOUR, 0, hour loaded at reset, in 24h form, legal range 0..23.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
run  input  1  1 = timekeeping advances; 0 = prescaler and time hold.
mode_24h  input  1  display mode: 1 = 24h, 0 = 12h; affects outputs only, never internal state.
ld  input  1  one-cycle load strobe.
ld_sec  input  6  load seconds.
ld_min  input  6  load minutes.
ld_hour  input  5  load hour, always in 24h form.
ld_err  output  1  one-cycle pulse: load rejected.
sec  output  6  seconds 0..59.
min  output  6  minutes 0..59.
hours  output  5  displayed hour: 0..23 in 24h mode, 1..12 in 12h mode.
pm  output  1  1 when internal hour is 12..23, in either mode.
sec_stb  output  1  pulse on every second advance.
min_stb  output  1  pulse on minute rollover.
hour_stb  output  1  pulse on hour rollover.
day_stb  output  1  pulse on 23:59:59 -> 00:00:00.
al_ld  input  1  alarm load strobe (ALARM_EN only).
al_min  input  6  alarm minute (ALARM_EN only).
al_hour  input  5  alarm hour, 24h form (ALARM_EN only).
alarm  output  1  alarm pulse (ALARM_EN only).

Behaviour:
- Internal state: sec_r, min_r, hour_r (0..23), prescaler pcnt of width max(1, clog2(CLK_DIV)).
- Reset (async assert, sync use on the next edge): sec_r=0, min_r=0, hour_r=RST_HOUR, pcnt=0, all strobes and ld_err=0.
- Prescaler: when run=1, pcnt increments; at pcnt==CLK_DIV-1 it wraps to 0 and asserts an internal tick. CLK_DIV=1 gives a tick every cycle. When run=0, pcnt holds and no tick occurs.
- Tick: sec_r advances, wrapping 59->0. On the sec wrap, min_r advances (59->0). On the min wrap, hour_r advances (23->0).
- Strobes: registered in the same edge as the state update, so each strobe is high for exactly the cycle in which the new value is visible. Strobe nesting: day_stb implies hour_stb implies min_stb implies sec_stb.
- Load:
  - ld=1 with ld_sec<=59, ld_min<=59, ld_hour<=23: state takes the loaded values next edge, pcnt clears to 0, no strobes fire.
  - Any field out of range: state unchanged, ld_err=1 for one cycle.
  - ld has priority over a coincident tick; that tick is discarded.
  - Load is accepted regardless of run.
- Display (combinational from state):
  - mode_24h=1: hours=hour_r.
  - mode_24h=0: hour_r 0 -> 12, 1..12 -> hour_r, 13..23 -> hour_r-12.
  - pm = (hour_r >= 12).
- Reset asserted mid-second discards the partial prescaler count.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined: al_ld captures al_min and al_hour into alarm registers, with the same range check; out-of-range asserts ld_err and keeps the old alarm. Alarm registers reset to 0:00.
  - alarm pulses one cycle, aligned with sec_stb, when a tick makes the time equal al_hour:al_min:00.
  - A load that lands on the alarm time does not fire.
  - If ld and al_ld coincide, both are processed; ld_err is the OR of both checks.
- Not defined: ports remain present; alarm is tied 0, al_* inputs are ignored, and no alarm registers are built.

Decomposition:
- Package rtc_pkg:
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Widths SEC_W=6, MIN_W=6, HOUR_W=5.
  - Function to_12h(hour) returning display hour.
- Sub-module rtc_prescaler (CLK_DIV parameter; inputs clk, rst, run, clr; output tick). Everything else stays in rtc_timekeeper.

Test Plan:
- CLK_DIV=4, rst then run=1 for 16 cycles -> sec_stb every 4th cycle, sec reaches 4; run=0 for 10 cycles -> sec holds at 4, no strobes.
- CLK_DIV=1, load 23:59:58, run 2 cycles -> 23:59:59, then 00:00:00 with sec_stb, min_stb, hour_stb and day_stb all high in the same cycle.
- Load ld_sec=60 (or ld_hour=24) -> ld_err for one cycle, time unchanged; load 13:05:00 with mode_24h=0 -> hours=1, pm=1; with mode_24h=1 -> hours=13.
- Hour 0 and hour 12 in 12h mode -> hours=12 with pm=0, and hours=12 with pm=1, respectively.
- ld coincident with a tick at CLK_DIV=3 -> loaded value shown, next sec_stb exactly 3 cycles later; async rst asserted mid-count -> all outputs to reset values without waiting for a clk edge.
- RTC_ALARM_EN: alarm 07:30, load 07:29:59, CLK_DIV=1 -> alarm pulses once with 07:30:00; load directly 07:30:00 -> no alarm.
